// File: rtl/sat_accumulator_pkg.sv
// Shared types and defaults for the saturating burst accumulator.
// Imported by the accumulator top and its interface users.
package accum_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'b00,
    S_ACC  = 2'b01,
    S_HOLD = 2'b10
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_COUNT = 4;

endpackage

// File: rtl/sat_accumulator_if.sv
// Operand-in / result-out handshake bundle for sat_accumulator.
// master drives operands and out_ready; slave is the accumulator.
interface sat_accumulator_if #(
  parameter int WIDTH = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_overflow;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum,
    input  out_overflow
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum,
    output out_overflow
  );

endinterface

// File: rtl/sat_accumulator_sat_add.sv
// Three-input unsigned saturating adder: acc + a + b clipped to all ones.
// sat flags any result that did not fit in WIDTH bits.
module sat_add #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             sat
);

  localparam logic [WIDTH+1:0] MAX =
    {2'b00, {WIDTH{1'b1}}};

  logic [WIDTH:0]   ab;
  logic [WIDTH+1:0] total;

  assign ab    = {1'b0, a} + {1'b0, b};
  assign total = {2'b00, acc} + {1'b0, ab};
  assign sat   = total > MAX;
  assign sum   = sat ? {WIDTH{1'b1}}
                     : total[WIDTH-1:0];

endmodule

// File: rtl/sat_accumulator.sv
// Burst accumulator: sums COUNT operand pairs with saturation,
// then holds the total and a sticky overflow flag until released.
module sat_accumulator
  import accum_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int COUNT = DEF_COUNT
) (
  input logic               clk,
  input logic               rst_n,
  sat_accumulator_if.slave  bus
);

  localparam int CW = $clog2(COUNT + 1);
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nx;
  logic             ovf;
  logic             ovf_nx;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nx;

  logic             in_rdy;
  logic             out_vld;
  logic             beat;
  logic             rel;
  logic [WIDTH-1:0] add_acc;
  logic [WIDTH-1:0] add_sum;
  logic             add_sat;

  // Handshake outputs come from registered state only.
  always_comb begin
    in_rdy  = 1'b1;
    out_vld = 1'b0;
    case (state)
      S_HOLD: begin
        in_rdy  = 1'b0;
        out_vld = 1'b1;
      end
      default: ;
    endcase
  end

  assign beat = bus.in_valid & in_rdy;
  assign rel  = out_vld & bus.out_ready;

  // First beat of a burst starts from zero.
  assign add_acc = (state == S_ACC) ? acc
                                    : '0;

  sat_add #(
    .WIDTH (WIDTH)
  ) u_add (
    .acc (add_acc),
    .a   (bus.in_a),
    .b   (bus.in_b),
    .sum (add_sum),
    .sat (add_sat)
  );

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    ovf_nx   = ovf;
    cnt_nx   = cnt;
    case (state)
      S_ACC: begin
        if (beat) begin
          acc_nx = add_sum;
          ovf_nx = ovf | add_sat;
          cnt_nx = cnt + ONE;
          if (cnt == LAST)
            state_nx = S_HOLD;
        end
      end
      S_HOLD: begin
        if (rel) begin
          state_nx = S_IDLE;
          acc_nx   = '0;
          ovf_nx   = 1'b0;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = S_IDLE;
        acc_nx   = '0;
        ovf_nx   = 1'b0;
        cnt_nx   = '0;
        if (beat) begin
          acc_nx   = add_sum;
          ovf_nx   = add_sat;
          cnt_nx   = ONE;
          state_nx = (COUNT == 1) ? S_HOLD
                                  : S_ACC;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      ovf   <= ovf_nx;
      cnt   <= cnt_nx;
    end
  end

  assign bus.in_ready     = in_rdy;
  assign bus.out_valid    = out_vld;
  assign bus.out_sum      = acc;
  assign bus.out_overflow = ovf;

endmodule

// File: doc/sat_accumulator.md
# sat_accumulator

Burst accumulator for 4-bit operand pairs with overflow detection and saturation. It sits directly downstream of the operand adder/next-state logic stage:
- accepts a stream of (a, b) operand pairs;
- sums COUNT pairs into a saturating accumulator;
- presents the result with a sticky overflow flag through a valid/ready handshake.

The block is lint-clean by construction: one driver per signal, full-case FSM, no inferred latches, all arithmetic widened before compare.

## Interface
- WIDTH, 4, operand and result width in bits (≥2)
- COUNT, 4, operand pairs per burst (≥1)
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept a pair this cycle
- in_a  in  WIDTH  operand a, unsigned
- in_b  in  WIDTH  operand b, unsigned
- out_valid  out  1  burst result available
- out_ready  in  1  consumer accepts result
- out_sum  out  WIDTH  saturated burst total
- out_overflow  out  1  any saturation occurred in the burst

## Operation
- States, 2-bit encoding:
  - S_IDLE=2'b00
  - S_ACC=2'b01
  - S_HOLD=2'b10
  - 2'b11 unused, decodes to S_IDLE via default arm
- Beat = in_valid && in_ready. Release = out_valid && out_ready.
- S_IDLE:
  - in_ready=1, acc=0, ovf=0, beat counter cnt=0.
  - On a beat: load acc with sat(a+b) and increment cnt.
  - Next state: S_ACC, or S_HOLD if COUNT==1.
- S_ACC:
  - in_ready=1.
  - On a beat: acc ← sat(acc + a + b) and increment cnt.
  - When cnt reaches COUNT, go to S_HOLD.
  - Non-beat cycles hold all state.
- S_HOLD:
  - in_ready=0, out_valid=1, out_sum=acc, out_overflow=ovf, all stable.
  - On release: go to S_IDLE; acc, ovf and cnt clear.
- Arithmetic:
  - a+b is formed in WIDTH+1 bits; acc+(a+b) in WIDTH+2 bits.
  - If the result exceeds 2^WIDTH−1, acc ← all ones and ovf ← 1.
  - ovf is sticky until release.
  - Once acc is saturated it stays saturated for the rest of the burst.
- cnt width is $clog2(COUNT+1); it never wraps within a burst.
- in_a/in_b are ignored whenever in_ready=0. in_valid in S_HOLD is neither consumed nor counted.

## Timing
- Reset values (rst_n=0 sampled at edge): state=S_IDLE, acc=0, ovf=0, cnt=0; outputs in_ready=1, out_valid=0, out_sum=0, out_overflow=0.
- Reset mid-burst or mid-hold aborts immediately. A pending result is dropped, not delivered.
- in_ready and out_valid are decoded from registered state only. No combinational path from in_valid or out_ready to any output.
- Latency: out_valid rises the cycle after the COUNT-th beat.
- Release cycle: out_valid=1 and in_ready=0. The next cycle is S_IDLE with in_ready=1, so there is a one-cycle bubble between bursts.
- Throughput: COUNT+1 cycles per burst minimum, plus consumer stall.
- out_ready low in S_HOLD holds out_sum/out_overflow indefinitely and unchanged.
- Input gaps (in_valid=0) in S_ACC extend the burst without affecting acc.

## Structure
- Package accum_pkg holds:
  - state localparams S_IDLE/S_ACC/S_HOLD and the 2-bit state width;
  - defaults for WIDTH and COUNT.
- Sub-module sat_add (combinational, parameter WIDTH):
  - inputs acc, a, b;
  - outputs the saturated sum and a sat flag.
  - This keeps the widening and compare logic in one place for reuse by sibling stages.
- Top level contains one sequential process (state, acc, ovf, cnt) and one combinational next-state process with a default arm.

## Test plan
- WIDTH=4, COUNT=4, pairs (1,2),(3,0),(2,2),(1,1) back-to-back → out_valid on cycle 5, out_sum=12, out_overflow=0.
- First pair (15,15), then (0,0)×3 → out_sum=15, out_overflow=1. Also pairs (4,4),(4,4) then (0,0)×2 → sum 16 saturates, out_sum=15, out_overflow=1.
- Hold result with out_ready=0 for 3 cycles while in_valid=1 → in_ready=0, out_sum stable, no beats counted. Then release → in_ready=1 the following cycle; a new burst sums correctly from 0.
- in_valid toggling 1,0,0,1,0,1,1 across a burst → exactly 4 beats counted; out_valid the cycle after the 4th beat.
- rst_n=0 for one cycle after 2 beats → next cycle in_ready=1, out_valid=0. The following 4-pair burst of (1,1) gives out_sum=8, with no carry-over.
- COUNT=1: single pair (7,9) → out_valid next cycle, out_sum=15, out_overflow=1. Release → back to S_IDLE.
